// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction cache and a data
// cache. A single FSM grants one side at a time, alternating on conflicts. Each
// access ends in one of four ways: the RAM reports ACCESS, a cycle-count timeout
// forces completion, the requester withdraws, or reset aborts it.
module mem_arbiter #(
    parameter int          TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [7:0]  err_cnt,
    output logic        timeout
);

    typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_grant_d;
    logic [7:0] acc_cnt;

    logic d_pend;
    logic i_pend;
    logic grant_d;
    logic grant_i;
    logic in_acc;
    logic still_req;
    logic hit;
    logic expire;

    // Request decode, conflict resolution and access-completion conditions
    always_comb begin
        d_pend    = dREN | dWEN;
        i_pend    = iREN;
        grant_d   = d_pend && (!i_pend || !last_grant_d);
        grant_i   = i_pend && !grant_d;
        in_acc    = (state == DACC) || (state == IACC);
        still_req = (state == DACC) ? d_pend : i_pend;
        hit       = (ramstate == RAM_ACCESS);
        expire    = (acc_cnt == CNT_LAST);
    end

    // The timeout pulse is visible in the last access cycle itself; ACCESS wins a tie
    assign timeout = !RST && in_acc && still_req && !hit && expire;

    // Arbiter FSM with registered RAM-side and cache-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            acc_cnt      <= 8'd0;
            err_cnt      <= 8'd0;
            iwait        <= 1'b1;
            dwait        <= 1'b1;
            iload        <= 32'd0;
            dload        <= 32'd0;
            ramREN       <= 1'b0;
            ramWEN       <= 1'b0;
            ramaddr      <= 32'd0;
            ramstore     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= DACC;
                        last_grant_d <= 1'b1;
                        acc_cnt      <= 8'd0;
                        ramaddr      <= daddr;
                        ramWEN       <= dWEN;
                        ramREN       <= !dWEN;
                        ramstore     <= dWEN ? dstore : 32'd0;
                    end else if (grant_i) begin
                        state        <= IACC;
                        last_grant_d <= 1'b0;
                        acc_cnt      <= 8'd0;
                        ramaddr      <= iaddr;
                        ramWEN       <= 1'b0;
                        ramREN       <= 1'b1;
                        ramstore     <= 32'd0;
                    end
                end
                DACC, IACC: begin
                    if (!still_req) begin
                        state    <= IDLE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= 32'd0;
                        ramstore <= 32'd0;
                    end else begin
                        if (ramstate == RAM_ERROR && err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        if (hit || expire) begin
                            ramREN   <= 1'b0;
                            ramWEN   <= 1'b0;
                            ramaddr  <= 32'd0;
                            ramstore <= 32'd0;
                            if (state == DACC) begin
                                state <= DRESP;
                                dwait <= 1'b0;
                                if (!ramWEN) begin
                                    dload <= hit ? ramload : TIMEOUT_WORD;
                                end
                            end else begin
                                state <= IRESP;
                                iwait <= 1'b0;
                                iload <= hit ? ramload : TIMEOUT_WORD;
                            end
                        end else begin
                            acc_cnt <= acc_cnt + 8'd1;
                        end
                    end
                end
                DRESP: begin
                    dwait <= 1'b1;
                    state <= IDLE;
                end
                IRESP: begin
                    iwait <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
